vmem_arbiter: RTL and testbench

//   Owns the single-port synchronous video text buffer and shares it between three users:

---
 rtl/vmem_arbiter.sv | 157 +++++++++++++++
 tb/tb_vmem_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vmem_arbiter.sv
// vmem_arbiter: single-port text buffer owner. Display reads win every cycle
// they ask, the clear engine sweeps on free cycles, the write port gets the rest.
module vmem_arbiter #(
  parameter int            AW        = 12,
  parameter int            DW        = 16,
  parameter int            DEPTH     = 2100,
  parameter logic [DW-1:0] CLR_VALUE = 16'h0720
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          disp_req_i,
  input  logic [AW-1:0] disp_addr_i,
  output logic          disp_rvalid_o,
  output logic [DW-1:0] disp_rdata_o,
  input  logic          wr_valid_i,
  output logic          wr_ready_o,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  output logic          wr_oob_o,
  input  logic          clr_start_i,
  output logic          clr_busy_o,
  output logic          clr_done_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
);

  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);
  // stage 0: RAM read issued, stage 1: RAM data on mem_rdata_i
  localparam int STAGES = 1;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t            state_q;
  logic [AW-1:0]     cnt_q;
  logic              clr_done_q;
  logic [STAGES:0]   vld_pipe_q;
  logic [STAGES:0]   inr_pipe_q;
  logic              rvalid_q;
  logic [DW-1:0]     rdata_q;
  logic              en_q, we_q, oob_q;
  logic [AW-1:0]     addr_q;
  logic [DW-1:0]     wdata_q;
  logic              en_d, we_d, oob_d;
  logic [AW-1:0]     addr_d;
  logic [DW-1:0]     wdata_d;

  logic disp_inr, wr_inr, wr_fire, clr_go;

  assign disp_inr   = ({1'b0, disp_addr_i} < DEPTH_W);
  assign wr_inr     = ({1'b0, wr_addr_i} < DEPTH_W);
  assign wr_ready_o = !disp_req_i && (state_q == IDLE);
  assign wr_fire    = wr_valid_i && wr_ready_o;
  // the sweep only advances on cycles the display leaves free
  assign clr_go     = (state_q == CLEAR) && !disp_req_i;

  // pick this cycle's single RAM owner; an out-of-range request still owns the slot
  always_comb begin
    en_d    = 1'b0;
    we_d    = 1'b0;
    oob_d   = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (disp_req_i) begin
      en_d   = disp_inr;
      addr_d = disp_addr_i;
    end else if (clr_go) begin
      en_d    = 1'b1;
      we_d    = 1'b1;
      addr_d  = cnt_q;
      wdata_d = CLR_VALUE;
    end else if (wr_fire) begin
      en_d    = wr_inr;
      we_d    = wr_inr;
      oob_d   = !wr_inr;
      addr_d  = wr_addr_i;
      wdata_d = wr_data_i;
    end
  end

  // registered RAM command and write-drop pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      oob_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      en_q    <= en_d;
      we_q    <= we_d;
      oob_q   <= oob_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // fixed-latency read return; out-of-range reads return zero, data holds between reads
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_pipe_q <= '0;
      inr_pipe_q <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:0], disp_req_i};
      inr_pipe_q <= {inr_pipe_q[STAGES-1:0], disp_inr};
      rvalid_q   <= vld_pipe_q[STAGES];
      if (vld_pipe_q[STAGES])
        rdata_q <= inr_pipe_q[STAGES] ? mem_rdata_i : '0;
    end
  end

  // clear engine: sweep 0..DEPTH-1 once, a new start while busy is ignored
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      clr_done_q <= 1'b0;
    end else begin
      clr_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clr_start_i) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
          end
        end
        CLEAR: begin
          if (clr_go) begin
            if (cnt_q == CNT_LAST) begin
              state_q    <= IDLE;
              clr_done_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign clr_busy_o    = (state_q == CLEAR);
  assign clr_done_o    = clr_done_q;
  assign wr_oob_o      = oob_q;
  assign disp_rvalid_o = rvalid_q;
  assign disp_rdata_o  = rdata_q;
  assign mem_en_o      = en_q;
  assign mem_we_o      = we_q;
  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_q;

endmodule

// File: tb/tb_vmem_arbiter.sv
// Bench for vmem_arbiter: behavioural RAM, a cycle model of the arbitration
// rules with a shadow image of the buffer, and a read scoreboard keyed by due edge.
module tb_vmem_arbiter;
  localparam int          AW    = 12;
  localparam int          DW    = 16;
  localparam int          DEPTH = 2100;
  localparam logic [15:0] CLR   = 16'h0720;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          disp_req = 1'b0, wr_valid = 1'b0, clr_start = 1'b0;
  logic [AW-1:0] disp_addr = '0, wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          disp_rvalid, wr_ready, wr_oob, clr_busy, clr_done;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] disp_rdata, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  vmem_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .CLR_VALUE(CLR)) dut (
    .clk_i(clk), .rst_i(rst),
    .disp_req_i(disp_req), .disp_addr_i(disp_addr),
    .disp_rvalid_o(disp_rvalid), .disp_rdata_o(disp_rdata),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .wr_oob_o(wr_oob),
    .clr_start_i(clr_start), .clr_busy_o(clr_busy), .clr_done_o(clr_done),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  function automatic logic [15:0] pat(int i);
    if (i == 16) return 16'h4141;
    return 16'(i * 7) ^ 16'h3C00;
  endfunction

  // synchronous single-port RAM, read data one cycle after the read is issued
  logic [DW-1:0] ram [0:4095];
  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = pat(i);
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        else        mem_rdata     <= ram[mem_addr];
      end
    end
  end

  typedef struct { int due; logic [15:0] data; } rd_t;
  rd_t sb[$];

  logic [15:0] ref_mem [0:4095];
  int   checks = 0, fails = 0, edge_n = 0;
  int   busy_cyc = 0, done_n = 0, oob_n = 0;
  bit   m_clear = 0;
  int   m_cnt = 0;
  bit   hs;
  logic e_en, e_we, e_oob, e_done, e_rst;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic [15:0]   last_rd = 16'h0;

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, act, exp, edge_n);
    end
  endtask

  // expected consequences of the inputs sampled at this edge
  task automatic model_edge();
    bit was_clear;
    was_clear = m_clear;
    e_en = 0; e_we = 0; e_oob = 0; e_done = 0; e_rst = 0;
    if (rst) begin
      m_clear = 0; m_cnt = 0; sb.delete(); last_rd = '0;
      e_rst = 1; e_addr = '0; e_wdata = '0;
    end else begin
      if (disp_req) begin
        if (disp_addr < DEPTH) begin
          e_en = 1; e_addr = disp_addr;
          sb.push_back('{edge_n + 2, ref_mem[disp_addr]});
        end else sb.push_back('{edge_n + 2, 16'h0});
      end else if (was_clear) begin
        e_en = 1; e_we = 1; e_addr = AW'(m_cnt); e_wdata = CLR;
        ref_mem[m_cnt] = CLR;
        if (m_cnt == DEPTH - 1) begin m_clear = 0; e_done = 1; end
        else m_cnt++;
      end else if (wr_valid) begin
        if (wr_addr < DEPTH) begin
          e_en = 1; e_we = 1; e_addr = wr_addr; e_wdata = wr_data;
          ref_mem[wr_addr] = wr_data;
        end else e_oob = 1;
      end
      if (!was_clear && clr_start) begin m_clear = 1; m_cnt = 0; end
    end
  endtask

  task automatic check_out();
    bit ev;
    chk("mem_en", mem_en, e_en);
    chk("mem_we", mem_we, e_we);
    if (e_en || e_rst) begin
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
    end
    chk("wr_oob", wr_oob, e_oob);
    chk("clr_busy", clr_busy, m_clear);
    chk("clr_done", clr_done, e_done);
    ev = (sb.size() > 0) && (sb[0].due == edge_n);
    chk("disp_rvalid", disp_rvalid, ev);
    if (ev) begin last_rd = sb[0].data; void'(sb.pop_front()); end
    chk("disp_rdata", disp_rdata, last_rd);
    if (clr_busy) busy_cyc++;
    if (clr_done) done_n++;
    if (wr_oob) oob_n++;
  endtask

  // one clock: check combinational ready, step the model on the edge, check registers
  task automatic tick();
    #1;
    if (edge_n > 0) chk("wr_ready", wr_ready, !disp_req && !m_clear);
    hs = wr_valid && !disp_req && !m_clear;
    @(posedge clk);
    edge_n++;
    model_edge();
    #1;
    check_out();
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit got;
    got = 0;
    wr_valid = 1; wr_addr = a; wr_data = d;
    for (int i = 0; i < 20 && !got; i++) begin tick(); got = hs; end
    wr_valid = 0;
    chk("wr_accept", got, 1);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    disp_req = 1; disp_addr = a; tick(); disp_req = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int bad, waited;
    for (int i = 0; i < 4096; i++) ref_mem[i] = pat(i);

    // reset
    idle(3);
    rst = 0;
    idle(2);

    // single display read of a preloaded cell
    rd(12'h010);
    idle(5);

    // write held off by a display burst, then read back
    wr_valid = 1; wr_addr = 12'h020; wr_data = 16'h0758;
    for (int i = 0; i < 4; i++) begin
      disp_req = 1; disp_addr = 12'(i + 8); tick();
      chk("t2_stall", hs, 0);
    end
    disp_req = 0;
    waited = 0;
    tick();
    while (!hs && waited < 10) begin tick(); waited++; end
    wr_valid = 0;
    chk("t2_accept_delay", waited, 0);
    idle(1);
    rd(12'h020);
    idle(4);

    // full clear with no display traffic
    busy_cyc = 0; done_n = 0;
    clr_start = 1; tick(); clr_start = 0;
    waited = 0;
    while (clr_busy && waited < 2300) begin tick(); waited++; end
    idle(2);
    chk("t3_busy_cycles", busy_cyc, 2100);
    chk("t3_done_pulses", done_n, 1);

    // scatter some data, then clear with alternating display reads
    for (int i = 0; i < 48; i++) wr(12'($urandom_range(0, DEPTH - 1)), 16'($urandom));
    busy_cyc = 0; done_n = 0;
    clr_start = 1; tick(); clr_start = 0;
    waited = 0;
    while (clr_busy && waited < 4500) begin
      disp_req  = (waited % 2 == 0);
      disp_addr = 12'($urandom_range(0, 4095));
      clr_start = (waited == 100);
      tick();
      waited++;
    end
    disp_req = 0; clr_start = 0;
    idle(4);
    chk("t4_busy_cycles", busy_cyc, 4200);
    chk("t4_done_pulses", done_n, 1);
    chk("t4_sb_drained", sb.size(), 0);

    // out-of-range accesses and the last valid address
    oob_n = 0;
    wr(12'd2100, 16'hDEAD);
    wr(12'd2099, 16'hBEEF);
    rd(12'd4095);
    rd(12'd2099);
    rd(12'd2100);
    idle(4);
    chk("t5_oob_pulses", oob_n, 1);

    // write + clear start together, then reset mid-sweep with a read in flight
    busy_cyc = 0; done_n = 0;
    wr_valid = 1; wr_addr = 12'd5; wr_data = 16'h1234; clr_start = 1;
    tick();
    chk("t6_wr_hs", hs, 1);
    wr_valid = 0; clr_start = 0;
    waited = 0;
    while (m_cnt < 1000 && waited < 1100) begin tick(); waited++; end
    chk("t6_reach_cnt", m_cnt, 1000);
    rd(12'h020);
    rst = 1; tick(); rst = 0;
    chk("t6_busy_after_rst", clr_busy, 0);
    idle(5);
    chk("t6_no_done", done_n, 0);

    // buffer image must match the shadow copy everywhere
    bad = 0;
    for (int i = 0; i < 4096; i++) if (ram[i] !== ref_mem[i]) bad++;
    chk("ram_image", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
